// File: rtl/ex_pkg.sv
// Shared constants for the EX stage: datapath widths, ALU opcode encodings and
// forwarding-select codes.
package ex_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int REG_ADDR_W_DEF = 3;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_SLT    = 3'd5;
    localparam logic [2:0] ALU_SHL    = 3'd6;
    localparam logic [2:0] ALU_PASS_B = 3'd7;

    // 2'b11 is unused by the forwarding unit and behaves like FWD_IDEX.
    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/ex_stage_reg_if.sv
// Bundle of ID/EX inputs, hazard controls, MEM/WB bypass value and EX/MEM outputs.
// master = upstream pipeline / hazard logic, slave = the EX stage.
interface ex_stage_reg_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic [DATA_W-1:0]     Id_Ex_r1Data;
    logic [DATA_W-1:0]     Id_Ex_r2Data;
    logic [DATA_W-1:0]     Id_Ex_imm;
    logic [2:0]            Id_Ex_aluOp;
    logic                  Id_Ex_aluSrc;
    logic [REG_ADDR_W-1:0] Id_Ex_dest;
    logic                  Id_Ex_regWrite;
    logic                  Id_Ex_regWriteDataSel;
    logic                  Id_Ex_memWrite;
    logic [1:0]            aluInputAForwardingSel;
    logic [1:0]            aluInputBForwardingSel;
    logic                  stall;
    logic                  flush;
    logic [DATA_W-1:0]     Mem_Wb_writeData;

    logic [DATA_W-1:0]     Ex_Mem_aluResult;
    logic [DATA_W-1:0]     Ex_Mem_storeData;
    logic [REG_ADDR_W-1:0] Ex_Mem_dest;
    logic                  Ex_Mem_regWrite;
    logic                  Ex_Mem_regWriteDataSel;
    logic                  Ex_Mem_memWrite;
    logic                  Ex_Mem_zero;

    modport master (
        output Id_Ex_r1Data, Id_Ex_r2Data, Id_Ex_imm, Id_Ex_aluOp, Id_Ex_aluSrc,
               Id_Ex_dest, Id_Ex_regWrite, Id_Ex_regWriteDataSel, Id_Ex_memWrite,
               aluInputAForwardingSel, aluInputBForwardingSel, stall, flush,
               Mem_Wb_writeData,
        input  Ex_Mem_aluResult, Ex_Mem_storeData, Ex_Mem_dest, Ex_Mem_regWrite,
               Ex_Mem_regWriteDataSel, Ex_Mem_memWrite, Ex_Mem_zero
    );

    modport slave (
        input  Id_Ex_r1Data, Id_Ex_r2Data, Id_Ex_imm, Id_Ex_aluOp, Id_Ex_aluSrc,
               Id_Ex_dest, Id_Ex_regWrite, Id_Ex_regWriteDataSel, Id_Ex_memWrite,
               aluInputAForwardingSel, aluInputBForwardingSel, stall, flush,
               Mem_Wb_writeData,
        output Ex_Mem_aluResult, Ex_Mem_storeData, Ex_Mem_dest, Ex_Mem_regWrite,
               Ex_Mem_regWriteDataSel, Ex_Mem_memWrite, Ex_Mem_zero
    );

endinterface

// File: rtl/ex_stage_reg_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR, signed SLT, SHL by b[3:0], PASS_B.
// Arithmetic wraps at DATA_W bits; zero flags an all-zero result.
module alu
    import ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        aluOp,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (aluOp)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLT:    result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SHL:    result = a << b[3:0];
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_reg.sv
// EX stage: operand forwarding muxes, ALU and the EX/MEM pipeline register.
// Optional EX_STALL_CNT_EN adds a saturating 16-bit stallCount output.
module ex_stage_reg
    import ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ex_stage_reg_if.slave bus
`ifdef EX_STALL_CNT_EN
    ,
    output logic [15:0]   stallCount
`endif
);

    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [DATA_W-1:0]     store_data_q, store_data_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  reg_write_q, reg_write_d;
    logic                  wb_sel_q, wb_sel_d;
    logic                  mem_write_q, mem_write_d;
    logic                  zero_q, zero_d;

    logic [1:0]            fwd_sel  [2];
    logic [DATA_W-1:0]     reg_data [2];
    logic [DATA_W-1:0]     fwd_data [2];
    logic [DATA_W-1:0]     alu_b;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_zero;
    logic                  bubble;

    assign fwd_sel[0]  = bus.aluInputAForwardingSel;
    assign fwd_sel[1]  = bus.aluInputBForwardingSel;
    assign reg_data[0] = bus.Id_Ex_r1Data;
    assign reg_data[1] = bus.Id_Ex_r2Data;

    // EX/MEM forwarding reads this stage's own registered result.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] = (fwd_sel[gi] == FWD_EXMEM) ? alu_result_q :
                                  (fwd_sel[gi] == FWD_MEMWB) ? bus.Mem_Wb_writeData :
                                                               reg_data[gi];
        end
    endgenerate

    assign alu_b = bus.Id_Ex_aluSrc ? bus.Id_Ex_imm : fwd_data[1];

    alu #(.DATA_W(DATA_W)) u_alu (
        .a      (fwd_data[0]),
        .b      (alu_b),
        .aluOp  (bus.Id_Ex_aluOp),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // A bubble only kills the side-effecting controls; data fields load anyway.
    assign bubble = bus.stall | bus.flush;

    always_comb begin
        alu_result_d = alu_res;
        zero_d       = alu_zero;
        store_data_d = fwd_data[1];
        dest_d       = bus.Id_Ex_dest;
        wb_sel_d     = bus.Id_Ex_regWriteDataSel;
        reg_write_d  = bus.Id_Ex_regWrite & ~bubble;
        mem_write_d  = bus.Id_Ex_memWrite & ~bubble;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
            wb_sel_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            dest_q       <= dest_d;
            reg_write_q  <= reg_write_d;
            wb_sel_q     <= wb_sel_d;
            mem_write_q  <= mem_write_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.Ex_Mem_aluResult       = alu_result_q;
    assign bus.Ex_Mem_storeData       = store_data_q;
    assign bus.Ex_Mem_dest            = dest_q;
    assign bus.Ex_Mem_regWrite        = reg_write_q;
    assign bus.Ex_Mem_regWriteDataSel = wb_sel_q;
    assign bus.Ex_Mem_memWrite        = mem_write_q;
    assign bus.Ex_Mem_zero            = zero_q;

`ifdef EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage_reg.sv
// Scoreboarded bench for ex_stage_reg: a driver applies directed vectors and queues
// hand-computed EX/MEM results; a monitor pops and compares after each edge.
module tb_ex_stage_reg;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_reg_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

`ifdef EX_STALL_CNT_EN
    logic [15:0] stallCount;
    ex_stage_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stallCount(stallCount));
`else
    ex_stage_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        string       name;
        logic        full;   // 0: only the bubble-relevant controls are checked
        logic [15:0] res;
        logic [15:0] store;
        logic [2:0]  dest;
        logic        rw;
        logic        wds;
        logic        mw;
        logic        zero;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string nm, input string field, input logic [15:0] act,
                       input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: the register updates every edge, so one expectation is due per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "regWrite", {15'd0, bus.Ex_Mem_regWrite}, {15'd0, e.rw});
                chk(e.name, "memWrite", {15'd0, bus.Ex_Mem_memWrite}, {15'd0, e.mw});
                if (e.full) begin
                    chk(e.name, "aluResult", bus.Ex_Mem_aluResult, e.res);
                    chk(e.name, "storeData", bus.Ex_Mem_storeData, e.store);
                    chk(e.name, "dest", {13'd0, bus.Ex_Mem_dest}, {13'd0, e.dest});
                    chk(e.name, "wbSel", {15'd0, bus.Ex_Mem_regWriteDataSel}, {15'd0, e.wds});
                    chk(e.name, "zero", {15'd0, bus.Ex_Mem_zero}, {15'd0, e.zero});
                end
`ifdef EX_STALL_CNT_EN
                chk(e.name, "stallCount", stallCount, e.cnt);
`endif
                $display("txn %-12s res=%h store=%h dest=%0d rw=%b mw=%b z=%b", e.name,
                         bus.Ex_Mem_aluResult, bus.Ex_Mem_storeData, bus.Ex_Mem_dest,
                         bus.Ex_Mem_regWrite, bus.Ex_Mem_memWrite, bus.Ex_Mem_zero);
            end
        end
    end

    // Driver: one vector per cycle, applied on the falling edge.
    task automatic step(input string nm, input logic r, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                        input logic src, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [15:0] mwb, input logic [2:0] dst, input logic rw,
                        input logic wds, input logic mw, input logic st, input logic fl,
                        input logic full, input logic [15:0] eres, input logic [15:0] estore,
                        input logic ezero);
        exp_t e;
        @(negedge clk);
        rst                        = r;
        bus.Id_Ex_aluOp            = op;
        bus.Id_Ex_r1Data           = a;
        bus.Id_Ex_r2Data           = b;
        bus.Id_Ex_imm              = imm;
        bus.Id_Ex_aluSrc           = src;
        bus.aluInputAForwardingSel = sa;
        bus.aluInputBForwardingSel = sb;
        bus.Mem_Wb_writeData       = mwb;
        bus.Id_Ex_dest             = dst;
        bus.Id_Ex_regWrite         = rw;
        bus.Id_Ex_regWriteDataSel  = wds;
        bus.Id_Ex_memWrite         = mw;
        bus.stall                  = st;
        bus.flush                  = fl;
        if (r) exp_cnt = 16'd0;
        else if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.name  = nm;
        e.full  = full;
        e.res   = r ? 16'd0 : eres;
        e.store = r ? 16'd0 : estore;
        e.dest  = r ? 3'd0 : dst;
        e.wds   = r ? 1'b0 : wds;
        e.rw    = (r || st || fl) ? 1'b0 : rw;
        e.mw    = (r || st || fl) ? 1'b0 : mw;
        e.zero  = r ? 1'b0 : ezero;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        //    name           rst op          A        B        imm      src sa     sb     mwb      dst  rw wds mw st fl full res      store    z
        step("reset0",       1, ALU_ADD,    16'd5,   16'd7,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd1, 1, 1, 0, 0, 0, 1, 16'd0,   16'd0,   0);
        step("reset1",       1, ALU_ADD,    16'd5,   16'd7,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd1, 1, 1, 0, 0, 0, 1, 16'd0,   16'd0,   0);
        step("add5_7",       0, ALU_ADD,    16'd5,   16'd7,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd1, 1, 1, 0, 0, 0, 1, 16'd12,  16'd7,   0);
        step("sub7_7",       0, ALU_SUB,    16'd7,   16'd7,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd1, 1, 1, 0, 0, 0, 1, 16'd0,   16'd7,   1);
        step("add3_4",       0, ALU_ADD,    16'd3,   16'd4,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd2, 1, 1, 0, 0, 0, 1, 16'd7,   16'd4,   0);
        step("fwdA_exmem",   0, ALU_SUB,    16'd100, 16'd2,   16'd0,   0, 2'b01, 2'b00, 16'd0,   3'd3, 1, 1, 0, 0, 0, 1, 16'd5,   16'd2,   0);
        step("fwdB_memwb",   0, ALU_AND,    16'h0FFF,16'h1234,16'd0,   0, 2'b00, 2'b10, 16'h00F0,3'd4, 1, 1, 0, 0, 0, 1, 16'h00F0,16'h00F0,0);
        step("imm_over_fwd", 0, ALU_AND,    16'h0FFF,16'h1234,16'd1,   1, 2'b00, 2'b10, 16'h00F0,3'd4, 1, 1, 0, 0, 0, 1, 16'd1,   16'h00F0,0);
        step("stall",        0, ALU_ADD,    16'd9,   16'h5555,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd5, 1, 0, 0, 1, 0, 0, 16'd0,   16'd0,   0);
        step("after_stall",  0, ALU_ADD,    16'd9,   16'h5555,16'd0,   0, 2'b00, 2'b10, 16'h0020,3'd5, 1, 0, 0, 0, 0, 1, 16'h0029,16'h0020,0);
        step("stall_flush",  0, ALU_ADD,    16'd1,   16'd1,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd6, 1, 1, 1, 1, 1, 0, 16'd0,   16'd0,   0);
        step("xor",          0, ALU_XOR,    16'hFF00,16'h0FF0,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd6, 1, 1, 0, 0, 0, 1, 16'hF0F0,16'h0FF0,0);
        step("add_wrap",     0, ALU_ADD,    16'hFFFF,16'd1,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd7, 1, 1, 0, 0, 0, 1, 16'd0,   16'd1,   1);
        step("slt_signed",   0, ALU_SLT,    16'h8000,16'd1,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd7, 1, 1, 0, 0, 0, 1, 16'd1,   16'd1,   0);
        step("or",           0, ALU_OR,     16'h000A,16'h0005,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd3, 1, 1, 0, 0, 0, 1, 16'h000F,16'h0005,0);
        step("store_fwdB",   0, ALU_ADD,    16'h0010,16'hDEAD,16'd0,   0, 2'b00, 2'b01, 16'd0,   3'd0, 0, 1, 1, 0, 0, 1, 16'h001F,16'h000F,0);
        step("shl",          0, ALU_SHL,    16'h0003,16'h0014,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd2, 1, 1, 0, 0, 0, 1, 16'h0030,16'h0014,0);
        step("pass_b",       0, ALU_PASS_B, 16'h1111,16'hBEEF,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd2, 1, 1, 0, 0, 0, 1, 16'hBEEF,16'hBEEF,0);
        step("flush_only",   0, ALU_ADD,    16'h0040,16'h0040,16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd1, 1, 1, 1, 0, 1, 1, 16'h0080,16'h0040,0);
        step("sel11_as_00",  0, ALU_ADD,    16'd2,   16'd3,   16'd0,   0, 2'b11, 2'b11, 16'h0700,3'd1, 1, 1, 0, 0, 0, 1, 16'd5,   16'd3,   0);
        step("stall2",       0, ALU_SUB,    16'd1,   16'd1,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd4, 1, 1, 1, 1, 0, 0, 16'd0,   16'd0,   0);
        step("reset_mid",    1, ALU_ADD,    16'd8,   16'd8,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd4, 1, 1, 1, 1, 0, 1, 16'd0,   16'd0,   0);
        step("post_reset",   0, ALU_ADD,    16'd8,   16'd8,   16'd0,   0, 2'b00, 2'b00, 16'd0,   3'd4, 1, 1, 0, 0, 0, 1, 16'd16,  16'd8,   0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
